// File: rtl/vga_pkg.sv
// Shared 800x600 raster timing constants for the timing generator and the shape renderers.
// Latency: none (constants only).
// Backpressure: none.
package vga_pkg;

    localparam int COORD_W = 11;

    localparam int H_TOTAL   = 1040;
    localparam int H_SYNC    = 120;
    localparam int H_VIS_MIN = 215;
    localparam int H_VIS_MAX = 1015;

    localparam int V_TOTAL   = 666;
    localparam int V_SYNC    = 6;
    localparam int V_VIS_MIN = 26;
    localparam int V_VIS_MAX = 626;

    localparam logic SYNC_ACTIVE = 1'b0;
    localparam int   PIX_DIV     = 1;

endpackage

// File: rtl/vga_pix_prescaler.sv
// Pixel-enable prescaler: divides clk by PIX_DIV.
// Latency: tick is combinational; pix_en is tick registered, first pulse PIX_DIV clks after reset.
// Backpressure: none, free-running.
module vga_pix_prescaler #(
    parameter int PIX_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick,
    output logic pix_en
);

    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // tick marks the edge at which the raster counters advance
    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            pix_en  <= 1'b0;
        end else begin
            pix_en  <= tick;
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: hc/vc counters, sync/vidon decode, line/frame strobes, frame counter.
// Latency: all outputs registered from next hc/vc, so sync/vidon align with the hc/vc they describe.
// Backpressure: none; counters advance on every pixel enable.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_TOTAL     = vga_pkg::H_TOTAL,
    parameter int   H_SYNC      = vga_pkg::H_SYNC,
    parameter int   H_VIS_MIN   = vga_pkg::H_VIS_MIN,
    parameter int   H_VIS_MAX   = vga_pkg::H_VIS_MAX,
    parameter int   V_TOTAL     = vga_pkg::V_TOTAL,
    parameter int   V_SYNC      = vga_pkg::V_SYNC,
    parameter int   V_VIS_MIN   = vga_pkg::V_VIS_MIN,
    parameter int   V_VIS_MAX   = vga_pkg::V_VIS_MAX,
    parameter logic SYNC_ACTIVE = vga_pkg::SYNC_ACTIVE,
    parameter int   PIX_DIV     = vga_pkg::PIX_DIV
) (
    input  logic               clk,
    input  logic               rst,
    output logic [COORD_W-1:0] hc,
    output logic [COORD_W-1:0] vc,
    output logic               vidon,
    output logic               hsync,
    output logic               vsync,
    output logic               pix_en,
    output logic               line_start,
    output logic               frame_start,
    output logic [7:0]         frame_cnt
);

    generate
        if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 11-bit counters");
        end
        if (H_VIS_MAX > H_TOTAL) begin : g_bad_hvis
            $error("vga_timing_gen: H_VIS_MAX beyond H_TOTAL");
        end
        if (PIX_DIV < 1) begin : g_bad_div
            $error("vga_timing_gen: PIX_DIV must be at least 1");
        end
    endgenerate

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_SW   = COORD_W'(H_SYNC);
    localparam logic [COORD_W-1:0] V_SW   = COORD_W'(V_SYNC);
    localparam logic [COORD_W-1:0] H_VLO  = COORD_W'(H_VIS_MIN);
    localparam logic [COORD_W-1:0] H_VHI  = COORD_W'(H_VIS_MAX);
    localparam logic [COORD_W-1:0] V_VLO  = COORD_W'(V_VIS_MIN);
    localparam logic [COORD_W-1:0] V_VHI  = COORD_W'(V_VIS_MAX);

    logic               tick;
    logic               line_wrap;
    logic               frame_wrap;
    logic [COORD_W-1:0] hc_n;
    logic [COORD_W-1:0] vc_n;
    logic               hsync_n;
    logic               vsync_n;
    logic               vidon_n;

    vga_pix_prescaler #(
        .PIX_DIV (PIX_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .pix_en (pix_en)
    );

    assign line_wrap  = (hc == H_LAST);
    assign frame_wrap = line_wrap && (vc == V_LAST);

    always_comb begin
        hc_n = hc + 1'b1;
        vc_n = vc;
        if (line_wrap) begin
            hc_n = '0;
            vc_n = (vc == V_LAST) ? '0 : vc + 1'b1;
        end
        // decode the position the counters are about to hold
        hsync_n = (hc_n < H_SW) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_n = (vc_n < V_SW) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vidon_n = (hc_n >= H_VLO) && (hc_n < H_VHI) && (vc_n >= V_VLO) && (vc_n < V_VHI);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hc          <= '0;
            vc          <= '0;
            hsync       <= SYNC_ACTIVE;
            vsync       <= SYNC_ACTIVE;
            vidon       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            line_start  <= tick && line_wrap;
            frame_start <= tick && frame_wrap;
            if (tick) begin
                hc    <= hc_n;
                vc    <= vc_n;
                hsync <= hsync_n;
                vsync <= vsync_n;
                vidon <= vidon_n;
                if (frame_wrap) begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance for real 800x600 edges, small instances for frame wrap and prescaler.
// Expected values come from pixel-index arithmetic on the number of clocks since reset release.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [10:0] hc;
        logic [10:0] vc;
        logic        vidon;
        logic        hsync;
        logic        vsync;
        logic        pix_en;
        logic        line_start;
        logic        frame_start;
        logic [7:0]  frame_cnt;
    } out_t;

    typedef struct packed {
        int   ht, hs, hmin, hmax, vt, vs, vmin, vmax, div;
        logic sa;
    } cfg_t;

    localparam cfg_t CFG_A = '{ht:1040, hs:120, hmin:215, hmax:1015, vt:666, vs:6, vmin:26, vmax:626, div:1, sa:1'b0};
    localparam cfg_t CFG_B = '{ht:16, hs:3, hmin:4, hmax:14, vt:8, vs:2, vmin:3, vmax:7, div:1, sa:1'b0};
    localparam cfg_t CFG_C = '{ht:16, hs:3, hmin:4, hmax:14, vt:8, vs:2, vmin:3, vmax:7, div:2, sa:1'b1};

    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    always #5 clk = ~clk;

    logic [10:0] hc_a, vc_a, hc_b, vc_b, hc_c, vc_c;
    logic        vid_a, hs_a, vs_a, pe_a, ls_a, fs_a;
    logic        vid_b, hs_b, vs_b, pe_b, ls_b, fs_b;
    logic        vid_c, hs_c, vs_c, pe_c, ls_c, fs_c;
    logic [7:0]  fc_a, fc_b, fc_c;

    vga_timing_gen dut_a (
        .clk(clk), .rst(rst_a), .hc(hc_a), .vc(vc_a), .vidon(vid_a), .hsync(hs_a), .vsync(vs_a),
        .pix_en(pe_a), .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a)
    );

    vga_timing_gen #(
        .H_TOTAL(16), .H_SYNC(3), .H_VIS_MIN(4), .H_VIS_MAX(14),
        .V_TOTAL(8), .V_SYNC(2), .V_VIS_MIN(3), .V_VIS_MAX(7), .SYNC_ACTIVE(1'b0), .PIX_DIV(1)
    ) dut_b (
        .clk(clk), .rst(rst_b), .hc(hc_b), .vc(vc_b), .vidon(vid_b), .hsync(hs_b), .vsync(vs_b),
        .pix_en(pe_b), .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b)
    );

    vga_timing_gen #(
        .H_TOTAL(16), .H_SYNC(3), .H_VIS_MIN(4), .H_VIS_MAX(14),
        .V_TOTAL(8), .V_SYNC(2), .V_VIS_MIN(3), .V_VIS_MAX(7), .SYNC_ACTIVE(1'b1), .PIX_DIV(2)
    ) dut_c (
        .clk(clk), .rst(rst_c), .hc(hc_c), .vc(vc_c), .vidon(vid_c), .hsync(hs_c), .vsync(vs_c),
        .pix_en(pe_c), .line_start(ls_c), .frame_start(fs_c), .frame_cnt(fc_c)
    );

    out_t obs_a, obs_b, obs_c;
    assign obs_a = {hc_a, vc_a, vid_a, hs_a, vs_a, pe_a, ls_a, fs_a, fc_a};
    assign obs_b = {hc_b, vc_b, vid_b, hs_b, vs_b, pe_b, ls_b, fs_b, fc_b};
    assign obs_c = {hc_c, vc_c, vid_c, hs_c, vs_c, pe_c, ls_c, fs_c, fc_c};

    // clock edges seen since each instance's reset was last released
    int k_a = 0, k_b = 0, k_c = 0;
    always @(posedge clk) begin
        k_a <= rst_a ? 0 : k_a + 1;
        k_b <= rst_b ? 0 : k_b + 1;
        k_c <= rst_c ? 0 : k_c + 1;
    end

    int n_chk = 0;
    int n_pass = 0;

    // Pixel p = k/div has been reached; position and frame follow from division by line/frame size.
    function automatic out_t model(input cfg_t c, input int k);
        out_t m;
        int   p, h, v, fr;
        logic pe;
        p  = k / c.div;
        pe = (k > 0) && (k % c.div == 0);
        h  = p % c.ht;
        v  = (p / c.ht) % c.vt;
        fr = (p / (c.ht * c.vt)) % 256;
        m.hc          = 11'(h);
        m.vc          = 11'(v);
        m.vidon       = (h >= c.hmin) && (h < c.hmax) && (v >= c.vmin) && (v < c.vmax);
        m.hsync       = (h < c.hs) ? c.sa : ~c.sa;
        m.vsync       = (v < c.vs) ? c.sa : ~c.sa;
        m.pix_en      = pe;
        m.line_start  = pe && (h == 0);
        m.frame_start = pe && (h == 0) && (v == 0);
        m.frame_cnt   = 8'(fr);
        return m;
    endfunction

    task automatic goto_a(input int hpos, input int vpos);
        int target;
        target = vpos * CFG_A.ht + hpos;
        if (target > k_a) repeat (target - k_a) @(negedge clk);
    endtask

    task automatic test_reset();
        out_t e;
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        repeat (3) @(negedge clk);
        e = '{hc:11'd0, vc:11'd0, vidon:1'b0, hsync:1'b0, vsync:1'b0, pix_en:1'b0,
              line_start:1'b0, frame_start:1'b0, frame_cnt:8'd0};
        n_chk++; if (obs_a !== e) $display("FAIL reset_state got %h want %h", obs_a, e); else n_pass++;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        @(negedge clk);
        n_chk++; if (hc_a !== 11'd1) $display("FAIL first_edge_hc got %0d want 1", hc_a); else n_pass++;
        n_chk++; if (fs_a !== 1'b0 || ls_a !== 1'b0) $display("FAIL release_strobe got fs=%b ls=%b want 0 0", fs_a, ls_a); else n_pass++;
        n_chk++; if (pe_a !== 1'b1) $display("FAIL first_pix_en got %b want 1", pe_a); else n_pass++;
    endtask

    task automatic test_vsync_edges();
        goto_a(0, 5);
        n_chk++; if (vs_a !== 1'b0) $display("FAIL vsync_vc5 got %b want 0", vs_a); else n_pass++;
        goto_a(0, 6);
        n_chk++; if (vs_a !== 1'b1) $display("FAIL vsync_vc6 got %b want 1", vs_a); else n_pass++;
    endtask

    task automatic test_line_wrap();
        goto_a(1039, 10);
        n_chk++; if (hc_a !== 11'd1039 || vc_a !== 11'd10 || ls_a !== 1'b0)
            $display("FAIL pre_wrap got (%0d,%0d) ls=%b want (1039,10) ls=0", hc_a, vc_a, ls_a); else n_pass++;
        @(negedge clk);
        n_chk++; if (hc_a !== 11'd0 || vc_a !== 11'd11)
            $display("FAIL line_wrap_pos got (%0d,%0d) want (0,11)", hc_a, vc_a); else n_pass++;
        n_chk++; if (ls_a !== 1'b1 || hs_a !== 1'b0 || fs_a !== 1'b0)
            $display("FAIL line_wrap_strobe got ls=%b hs=%b fs=%b want 1 0 0", ls_a, hs_a, fs_a); else n_pass++;
        @(negedge clk);
        n_chk++; if (ls_a !== 1'b0 || hc_a !== 11'd1)
            $display("FAIL line_start_width got ls=%b hc=%0d want 0 1", ls_a, hc_a); else n_pass++;
    endtask

    task automatic test_sync_vis_edges();
        int pts [6][3] = '{'{119, 11, 0}, '{120, 11, 1}, '{214, 26, 0}, '{215, 26, 1}, '{1014, 26, 1}, '{1015, 26, 0}};
        for (int i = 0; i < 6; i++) begin
            goto_a(pts[i][0], pts[i][1]);
            if (i < 2) begin
                n_chk++; if (hs_a !== 1'(pts[i][2]))
                    $display("FAIL hsync_edge hc=%0d got %b want %0d", hc_a, hs_a, pts[i][2]); else n_pass++;
            end else begin
                n_chk++; if (vid_a !== 1'(pts[i][2]))
                    $display("FAIL vidon_edge (%0d,%0d) got %b want %0d", hc_a, vc_a, vid_a, pts[i][2]); else n_pass++;
            end
            n_chk++; if (obs_a !== model(CFG_A, k_a))
                $display("FAIL edge_full k=%0d got %h want %h", k_a, obs_a, model(CFG_A, k_a)); else n_pass++;
        end
    endtask

    task automatic test_random_a();
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(1, 150)) @(negedge clk);
            n_chk++; if (obs_a !== model(CFG_A, k_a))
                $display("FAIL random_a k=%0d got %h want %h", k_a, obs_a, model(CFG_A, k_a)); else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        goto_a(500, 30);
        n_chk++; if (vid_a !== 1'b1 || hc_a !== 11'd500 || vc_a !== 11'd30)
            $display("FAIL mid_pre got (%0d,%0d) vid=%b want (500,30) 1", hc_a, vc_a, vid_a); else n_pass++;
        rst_a = 1'b1;
        @(negedge clk);
        n_chk++; if (hc_a !== 11'd0 || vc_a !== 11'd0 || vid_a !== 1'b0 || fc_a !== 8'd0 || fs_a !== 1'b0 || pe_a !== 1'b0)
            $display("FAIL mid_reset got %h want hc=vc=vid=fc=fs=pe=0", obs_a); else n_pass++;
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        n_chk++; if (hc_a !== 11'd1 || fs_a !== 1'b0)
            $display("FAIL mid_release got hc=%0d fs=%b want 1 0", hc_a, fs_a); else n_pass++;
    endtask

    task automatic test_frame_wrap();
        int fsz, pe_cnt, probe;
        fsz = CFG_B.ht * CFG_B.vt;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
        pe_cnt = 0;
        for (int f = 0; f < 256; f++) begin
            probe = f * fsz + $urandom_range(1, fsz - 2);
            while (k_b < (f + 1) * fsz - 1) begin
                @(negedge clk);
                pe_cnt += int'(pe_b);
                if (f == 0 || k_b == probe) begin
                    n_chk++; if (obs_b !== model(CFG_B, k_b))
                        $display("FAIL frame_full k=%0d got %h want %h", k_b, obs_b, model(CFG_B, k_b)); else n_pass++;
                end
            end
            n_chk++; if (hc_b !== 11'd15 || vc_b !== 11'd7 || fs_b !== 1'b0)
                $display("FAIL last_pixel f=%0d got (%0d,%0d) fs=%b want (15,7) 0", f, hc_b, vc_b, fs_b); else n_pass++;
            @(negedge clk);
            pe_cnt += int'(pe_b);
            n_chk++; if (hc_b !== 11'd0 || vc_b !== 11'd0 || fs_b !== 1'b1 || fc_b !== 8'((f + 1) % 256))
                $display("FAIL frame_wrap f=%0d got (%0d,%0d) fs=%b fc=%0d want (0,0) 1 %0d", f, hc_b, vc_b, fs_b, fc_b, (f + 1) % 256); else n_pass++;
            n_chk++; if (pe_cnt !== fsz)
                $display("FAIL pix_per_frame f=%0d got %0d want %0d", f, pe_cnt, fsz); else n_pass++;
            pe_cnt = 0;
        end
        @(negedge clk);
        n_chk++; if (fs_b !== 1'b0 || fc_b !== 8'd0)
            $display("FAIL fc_wrap got fs=%b fc=%0d want 0 0", fs_b, fc_b); else n_pass++;
    endtask

    task automatic test_prescaler();
        logic [10:0] ph, pv;
        rst_c = 1'b1;
        repeat (3) @(negedge clk);
        rst_c = 1'b0;
        @(negedge clk);
        n_chk++; if (pe_c !== 1'b0 || hc_c !== 11'd0 || hs_c !== 1'b1)
            $display("FAIL div_first got pe=%b hc=%0d hs=%b want 0 0 1", pe_c, hc_c, hs_c); else n_pass++;
        @(negedge clk);
        n_chk++; if (pe_c !== 1'b1 || hc_c !== 11'd1)
            $display("FAIL div_second got pe=%b hc=%0d want 1 1", pe_c, hc_c); else n_pass++;
        ph = hc_c; pv = vc_c;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n_chk++; if (obs_c !== model(CFG_C, k_c))
                $display("FAIL div_full k=%0d got %h want %h", k_c, obs_c, model(CFG_C, k_c)); else n_pass++;
            if (!pe_c) begin
                n_chk++; if (hc_c !== ph || vc_c !== pv || ls_c !== 1'b0 || fs_c !== 1'b0)
                    $display("FAIL div_hold k=%0d got (%0d,%0d) want (%0d,%0d) no strobes", k_c, hc_c, vc_c, ph, pv); else n_pass++;
            end
            ph = hc_c; pv = vc_c;
        end
    endtask

    initial begin
        test_reset();
        test_vsync_edges();
        test_line_wrap();
        test_sync_vis_edges();
        test_random_a();
        test_mid_reset();
        test_frame_wrap();
        test_prescaler();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Raster timing generator for the 800x600 playfield. Drives the shared pixel coordinates hc/vc, the video-enable vidon, and the hsync/vsync pins. Every shape renderer (triangle, square, parallelogram) consumes hc/vc/vidon in parallel. It also issues per-line and per-frame strobes, which renderers use for move and rotate pacing.

Parameters:
H_TOTAL, 1040, pixel clocks per line (hc counts 0..H_TOTAL-1)
H_SYNC, 120, hsync pulse width in clocks, starting at hc=0
H_VIS_MIN, 215, first visible column
H_VIS_MAX, 1015, first non-visible column after the visible region (800 columns visible)
V_TOTAL, 666, lines per frame (vc counts 0..V_TOTAL-1)
V_SYNC, 6, vsync pulse width in lines, starting at vc=0
V_VIS_MIN, 26, first visible line
V_VIS_MAX, 626, first non-visible line after the visible region (600 lines visible)
SYNC_ACTIVE, 1'b0, sync pulse level (0 = active-low)
PIX_DIV, 1, clk cycles per pixel (1..4); counters advance only on pixel-enable cycles

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
hc  output  11  horizontal pixel counter
vc  output  11  vertical line counter
vidon  output  1  1 when H_VIS_MIN<=hc<H_VIS_MAX and V_VIS_MIN<=vc<V_VIS_MAX
hsync  output  1  SYNC_ACTIVE while hc<H_SYNC, else ~SYNC_ACTIVE
vsync  output  1  SYNC_ACTIVE while vc<V_SYNC, else ~SYNC_ACTIVE
pix_en  output  1  one-clk pulse on each pixel advance
line_start  output  1  one-clk pulse coincident with the pix_en that sets hc to 0
frame_start  output  1  one-clk pulse coincident with the pix_en that sets hc=0, vc=0
frame_cnt  output  8  frame counter; increments with frame_start, wraps 255->0

Behaviour:
- Reset (rst=1 at a clock edge):
  - hc=0, vc=0, frame_cnt=0.
  - hsync=SYNC_ACTIVE, vsync=SYNC_ACTIVE, vidon=0.
  - pix_en=0, line_start=0, frame_start=0.
  - Prescaler cleared.
  - Reset overrides everything, including mid-line and mid-frame.
- Prescaler:
  - div_cnt counts 0..PIX_DIV-1.
  - pix_en=1 on the cycle after div_cnt reaches PIX_DIV-1.
  - With PIX_DIV=1, pix_en=1 on every cycle after reset release.
  - First pix_en occurs PIX_DIV cycles after rst falls.
- Counter advance (only on pix_en cycles):
  - hc <= (hc==H_TOTAL-1) ? 0 : hc+1.
  - On hc wrap: vc <= (vc==V_TOTAL-1) ? 0 : vc+1.
  - vc changes only on an hc wrap.
- Output registration:
  - All outputs are registers, decoded from the next hc/vc values.
  - hsync/vsync/vidon are therefore aligned with the hc/vc they describe: zero relative latency.
  - Between pix_en cycles all outputs hold their values, except the strobes, which are 0.
- Strobes:
  - line_start=1 for exactly one clk when hc becomes 0.
  - frame_start=1 when hc and vc both become 0; frame_cnt increments in the same cycle.
  - Reset is not a frame start: no strobe on reset release.
- Boundary values:
  - hc=H_VIS_MAX-1=1014 is visible; hc=1015 is not.
  - vc=625 is visible; vc=626 is not.
  - hc=H_SYNC-1=119 is in sync; hc=120 is not.
  - Last pixel of a frame is (1039,665); next is (0,0) with frame_start.
- Widths: hc and vc are 11 bits unsigned; all comparisons are unsigned.
- Elaboration-time parameter checks:
  - H_TOTAL<=2047 and V_TOTAL<=2047.
  - H_VIS_MAX<=H_TOTAL.
  - PIX_DIV>=1.
- Frame rate: 1040*666 pixel clocks per frame; 50 MHz with PIX_DIV=1 gives about 72 Hz.

Decomposition:
- Shared package vga_pkg holds:
  - The 800x600 timing constants listed above.
  - COORD_W=11.
  - The playfield bounds H_VIS_MIN/MAX and V_VIS_MIN/MAX. The shape renderers reference the same constants for clipping and start positions.
- One natural sub-module, vga_pix_prescaler, generates pix_en.
- Counters and decode stay in vga_timing_gen.

Test Plan:
- Reset: hold rst 3 clk, release -> hc=0, vc=0, hsync=vsync=0, vidon=0. With PIX_DIV=1, the first edge after release gives hc=1 and no frame_start.
- Line wrap: run to hc=1039, vc=10 -> next pix_en gives hc=0, vc=11, line_start=1 for 1 clk, hsync=0.
- Sync and visible edges: check hsync=0 at hc=119 and 1 at hc=120. Check vidon at (214,26)=0, (215,26)=1, (1014,625)=1, (1015,625)=0, (215,626)=0.
- Frame wrap: (1039,665) -> (0,0), frame_start=1 for one clk, frame_cnt 0->1. Run 256 frames -> frame_cnt wraps to 0. Measure exactly 692640 pix_en per frame.
- Prescaler: PIX_DIV=2 -> pix_en every other clk, hc advances once per 2 clk, outputs stable on non-enable cycles.
- Mid-frame reset: assert rst at (500,300) with vidon=1 -> next edge gives hc=0, vc=0, vidon=0, frame_cnt=0, no frame_start pulse.
